// File: rtl/mult_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : mult_rr_sched
// Purpose  : Round-robin front end for one shared two-stage registered
//            multiplier. Up to NUM_REQ requesters offer operand pairs. One
//            of them is granted per cycle, and its operands go to the
//            multiplier. A two-stage tag pipeline follows the multiplier's
//            register stages, so each product that comes back carries the
//            ID of the requester that owns it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH   operand width (product is 2*DATA_WIDTH)
//   NUM_REQ      number of requesters, 2..8
//   ID_W         requester-ID width, clog2(NUM_REQ)
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   iv_req_valid per-requester request
//   iv_req_a/b   packed operands, slice k belongs to requester k
//   ov_req_ready one-hot grant (or zero)
//   o_mul_en     advance enable for both multiplier register stages
//   ov_mul_a/b   operands to the multiplier
//   iv_mul_prod  registered product from the multiplier
//   o_res_valid  result available
//   ov_res_prod  result product (iv_mul_prod passed through)
//   ov_res_id    owner of the current result
//   i_res_ready  consumer accepts the result
//   o_idle       no operation in flight
// ============================================================================
module mult_rr_sched #(
   parameter int DATA_WIDTH = 4,
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            iv_req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] iv_req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] iv_req_b,
   output logic [NUM_REQ-1:0]            ov_req_ready,
   output logic                          o_mul_en,
   output logic [DATA_WIDTH-1:0]         ov_mul_a,
   output logic [DATA_WIDTH-1:0]         ov_mul_b,
   input  logic [2*DATA_WIDTH-1:0]       iv_mul_prod,
   output logic                          o_res_valid,
   output logic [2*DATA_WIDTH-1:0]       ov_res_prod,
   output logic [ID_W-1:0]               ov_res_id,
   input  logic                          i_res_ready,
   output logic                          o_idle
);

   // The pointer starts at the last requester, so requester 0 is searched
   // first after reset.
   localparam logic [ID_W-1:0] c_ptr_rst = ID_W'(NUM_REQ - 1);
   localparam logic [ID_W:0]   c_num_req = (ID_W + 1)'(NUM_REQ);

   // Tag pipeline. It is the bookkeeping twin of the multiplier's operand
   // and product registers.
   logic            r_s1_valid;
   logic [ID_W-1:0] r_s1_id;
   logic            r_s2_valid;
   logic [ID_W-1:0] r_s2_id;
   logic [ID_W-1:0] r_ptr;

   logic            w_stall;
   logic            w_found;
   logic [ID_W-1:0] w_idx;
   logic [ID_W:0]   w_sum;
   logic            w_xfer;

   // -------------------------------------------------------------------------
   // Stall: the oldest result cannot leave, so nothing may move. This term
   // depends only on registered state and the consumer. Request valids never
   // reach o_mul_en.
   // -------------------------------------------------------------------------
   assign w_stall  = r_s2_valid & ~i_res_ready;

   // During reset the enable is forced high. The multiplier then flushes the
   // zero operands through both of its stages.
   assign o_mul_en = i_rst | ~w_stall;

   // -------------------------------------------------------------------------
   // Round-robin search, starting at ptr+1 and wrapping. The one-bit-wider
   // sum keeps the wrap exact for non-power-of-two NUM_REQ.
   // -------------------------------------------------------------------------
   always_comb begin
      w_found = 1'b0;
      w_idx   = r_ptr;
      w_sum   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_sum = {1'b0, r_ptr} + (ID_W + 1)'(i);
         if (w_sum >= c_num_req) begin
            w_sum = w_sum - c_num_req;
         end
         if (!w_found && iv_req_valid[w_sum[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_idx   = w_sum[ID_W-1:0];
         end
      end
   end

   assign w_xfer = w_found & ~w_stall & ~i_rst;

   // Grant and operand mux. Operands are zero when nothing is granted, so
   // bubbles enter the multiplier as 0*0.
   always_comb begin
      ov_req_ready = '0;
      ov_mul_a     = '0;
      ov_mul_b     = '0;
      if (w_xfer) begin
         ov_req_ready[w_idx] = 1'b1;
         ov_mul_a = iv_req_a[w_idx*DATA_WIDTH +: DATA_WIDTH];
         ov_mul_b = iv_req_b[w_idx*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // -------------------------------------------------------------------------
   // State update. Everything advances together with the multiplier, so tags
   // and products stay aligned through stalls.
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1_valid <= 1'b0;
         r_s1_id    <= '0;
         r_s2_valid <= 1'b0;
         r_s2_id    <= '0;
         r_ptr      <= c_ptr_rst;
      end else if (o_mul_en) begin
         r_s1_valid <= w_xfer;
         r_s1_id    <= w_xfer ? w_idx : '0;
         r_s2_valid <= r_s1_valid;
         r_s2_id    <= r_s1_id;
         if (w_xfer) begin
            r_ptr <= w_idx;
         end
      end
   end

   // Result side is purely combinational from the last tag stage.
   assign o_res_valid = r_s2_valid;
   assign ov_res_id   = r_s2_id;
   assign ov_res_prod = iv_mul_prod;
   assign o_idle      = ~(r_s1_valid | r_s2_valid);

endmodule
`default_nettype wire
